// File: rtl/notas_pkg.sv
// Shared constants for the seven-segment display mux: code width and
// active-high segment patterns (bit 0 = a ... bit 6 = g).
package notas_pkg;

  localparam int CODE_W = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h7C;
  localparam seg_t SEG_C     = 7'h39;
  localparam seg_t SEG_D     = 7'h5E;
  localparam seg_t SEG_E     = 7'h79;
  localparam seg_t SEG_F     = 7'h71;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/notas_display_mux_seg7_decode.sv
// Pure combinational 4-bit code to active-high segment pattern.
// Polarity and blanking are applied by the caller.
module seg7_decode
  import notas_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  input  logic              hex_mode,
  output logic [6:0]        pattern
);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0: pattern = SEG_0;
      4'h1: pattern = SEG_1;
      4'h2: pattern = SEG_2;
      4'h3: pattern = SEG_3;
      4'h4: pattern = SEG_4;
      4'h5: pattern = SEG_5;
      4'h6: pattern = SEG_6;
      4'h7: pattern = SEG_7;
      4'h8: pattern = SEG_8;
      4'h9: pattern = SEG_9;
      4'hA: pattern = hex_mode ? SEG_A : SEG_DASH;
      4'hB: pattern = hex_mode ? SEG_B : SEG_DASH;
      4'hC: pattern = hex_mode ? SEG_C : SEG_DASH;
      4'hD: pattern = hex_mode ? SEG_D : SEG_DASH;
      4'hE: pattern = hex_mode ? SEG_E : SEG_DASH;
      4'hF: pattern = hex_mode ? SEG_F : SEG_DASH;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/notas_display_mux.sv
// Time-multiplexed common-anode seven-segment driver: shadow-latched digit
// codes, per-digit slots with one dead cycle, optional leading-zero blanking.
module notas_display_mux
  import notas_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter bit HEX_MODE    = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ready,
  input  logic [CODE_W*NUM_DIGITS-1:0] value,
  input  logic                         lz_en,
  output logic [6:0]                   seg,
  output logic [NUM_DIGITS-1:0]        digit_en,
  output logic                         busy
);

  localparam int DIV_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam seg_t                  SEG_OFF  = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [CODE_W*NUM_DIGITS-1:0] shadow_code;
  logic                         shadow_lz;
  logic [DIV_W-1:0]             div_cnt;
  logic [IDX_W-1:0]             scan_idx;

  logic [CODE_W-1:0]     cur_code;
  seg_t                  dec_pat;
  seg_t                  lit_pat;
  logic [NUM_DIGITS-1:0] blank_mask;
  logic [NUM_DIGITS-1:0] sel_onehot;
  logic                  upper_zero;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow register is reset on purpose; the first scan after
      // reset must show code 0 rather than whatever was left in the flops.
      shadow_code <= '0;
      shadow_lz   <= 1'b0;
      div_cnt     <= '0;
      scan_idx    <= '0;
    end else begin
      if (ready) begin
        shadow_code <= value;
        shadow_lz   <= lz_en;
      end
      if (div_cnt == DIV_LAST) begin
        div_cnt  <= '0;
        scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Digit i is blank when it and every more-significant code are zero;
  // the scan runs from the top digit down so the zero run accumulates.
  always_comb begin
    blank_mask = '0;
    upper_zero = shadow_lz;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      upper_zero    = upper_zero && (shadow_code[CODE_W*i +: CODE_W] == '0);
      blank_mask[i] = upper_zero;
    end
  end

  assign cur_code   = shadow_code[CODE_W*int'(scan_idx) +: CODE_W];
  assign sel_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << scan_idx;

  seg7_decode u_decode (
    .code     (cur_code),
    .hex_mode (HEX_MODE),
    .pattern  (dec_pat)
  );

  assign lit_pat = blank_mask[scan_idx] ? SEG_BLANK : dec_pat;

  // Divider value 0 is the dead cycle between digits, which keeps two digits
  // from ever being enabled at once while the index moves.
  always_ff @(posedge clk) begin
    if (reset || (div_cnt == '0)) begin
      seg      <= SEG_OFF;
      digit_en <= EN_OFF;
      busy     <= 1'b1;
    end else begin
      seg      <= ACTIVE_LOW ? ~lit_pat : lit_pat;
      digit_en <= ACTIVE_LOW ? ~sel_onehot : sel_onehot;
      busy     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_notas_display_mux.sv
// Self-checking bench for notas_display_mux: two instances (hex and dash
// mode) compared every cycle against a slot/time-based reference model.
module tb_notas_display_mux;

  localparam int ND = 4;
  localparam int RD = 4;

  localparam logic [6:0] REF_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ready = 1'b0;
  logic        lz_en = 1'b0;
  logic [15:0] value = '0;

  logic [6:0] seg, seg_nh;
  logic [3:0] digit_en, digit_en_nh;
  logic       busy, busy_nh;

  int checks = 0;
  int passed = 0;

  // Reference model state: shadow contents and edges since reset release.
  logic [15:0] m_code = '0;
  logic        m_lz = 1'b0;
  int          m_n = 0;
  int          m_idx = 0;
  int          m_div = 0;
  logic [6:0]  exp_seg, exp_seg_nh;
  logic [3:0]  exp_en;
  logic        exp_busy;

  always #5 clk = ~clk;

  notas_display_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1), .HEX_MODE(1'b1)) dut (
    .clk(clk), .reset(reset), .ready(ready), .value(value), .lz_en(lz_en),
    .seg(seg), .digit_en(digit_en), .busy(busy)
  );

  notas_display_mux #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .ACTIVE_LOW(1'b1), .HEX_MODE(1'b0)) dut_nh (
    .clk(clk), .reset(reset), .ready(ready), .value(value), .lz_en(lz_en),
    .seg(seg_nh), .digit_en(digit_en_nh), .busy(busy_nh)
  );

  function automatic logic [6:0] ref_pattern(int code, bit hex);
    if (!hex && code >= 10) return 7'h40;
    return REF_TBL[code];
  endfunction

  // Advance one clock edge, derive the expected outputs from the model state
  // before the edge, then apply this edge's reset/load to the model.
  task automatic step();
    int   code;
    logic blank;
    @(posedge clk);
    if (reset) begin
      exp_seg = 7'h7F; exp_seg_nh = 7'h7F; exp_en = 4'hF; exp_busy = 1'b1;
      m_code = '0; m_lz = 1'b0; m_n = 0;
    end else begin
      m_div = m_n % RD;
      m_idx = (m_n / RD) % ND;
      if (m_div == 0) begin
        exp_seg = 7'h7F; exp_seg_nh = 7'h7F; exp_en = 4'hF; exp_busy = 1'b1;
      end else begin
        code       = int'((m_code >> (4 * m_idx)) & 16'hF);
        blank      = m_lz && (m_idx != 0) && ((m_code >> (4 * m_idx)) == 16'd0);
        exp_en     = ~(4'b0001 << m_idx);
        exp_seg    = blank ? 7'h7F : ~ref_pattern(code, 1'b1);
        exp_seg_nh = blank ? 7'h7F : ~ref_pattern(code, 1'b0);
        exp_busy   = 1'b0;
      end
      if (ready) begin
        m_code = value;
        m_lz   = lz_en;
      end
      m_n++;
    end
    #1;
  endtask

  task automatic load(input logic [15:0] v, input logic lz);
    value = v; lz_en = lz; ready = 1'b1;
    step();
    ready = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({seg, digit_en, busy, seg_nh, digit_en_nh, busy_nh} !== {7'h7F, 4'hF, 1'b1, 7'h7F, 4'hF, 1'b1}) begin
        $display("FAIL reset_hold cycle %0d: seg=%h en=%h busy=%b, expected seg=7f en=f busy=1", i, seg, digit_en, busy);
      end else passed++;
    end
    reset = 1'b0;
    step();
    checks++;
    if ({seg, digit_en, busy} !== {7'h7F, 4'hF, 1'b1}) begin
      $display("FAIL reset_release_dead: seg=%h en=%h busy=%b, expected seg=7f en=f busy=1", seg, digit_en, busy);
    end else passed++;
    step();
    checks++;
    if ({seg, digit_en, busy} !== {~7'h3F, 4'hE, 1'b0}) begin
      $display("FAIL first_digit0: seg=%h en=%h busy=%b, expected seg=%h en=e busy=0", seg, digit_en, busy, ~7'h3F);
    end else passed++;
  endtask

  task automatic test_scan();
    load(16'h1234, 1'b0);
    for (int i = 0; i < 2 * ND * RD; i++) begin
      step();
      checks++;
      if ({seg, digit_en, busy, seg_nh, digit_en_nh} !== {exp_seg, exp_en, exp_busy, exp_seg_nh, exp_en}) begin
        $display("FAIL scan: seg=%h en=%h busy=%b seg_nh=%h, expected seg=%h en=%h busy=%b seg_nh=%h",
                 seg, digit_en, busy, seg_nh, exp_seg, exp_en, exp_busy, exp_seg_nh);
      end else passed++;
      if (!exp_busy && m_idx == 0) begin
        checks++;
        if ({seg, digit_en} !== {~7'h66, 4'hE}) begin
          $display("FAIL scan_digit0_is_4: seg=%h en=%h, expected seg=%h en=e", seg, digit_en, ~7'h66);
        end else passed++;
      end
    end
  endtask

  task automatic test_leading_zero();
    for (int pass = 0; pass < 2; pass++) begin
      load(pass == 0 ? 16'h0070 : 16'h0000, 1'b1);
      for (int i = 0; i < ND * RD + 2; i++) begin
        step();
        checks++;
        if ({seg, digit_en, busy, seg_nh} !== {exp_seg, exp_en, exp_busy, exp_seg_nh}) begin
          $display("FAIL leading_zero: seg=%h en=%h busy=%b, expected seg=%h en=%h busy=%b",
                   seg, digit_en, busy, exp_seg, exp_en, exp_busy);
        end else passed++;
        if (!exp_busy && m_idx == 3) begin
          checks++;
          if ({seg, digit_en} !== {7'h7F, 4'h7}) begin
            $display("FAIL lz_digit3_blank: seg=%h en=%h, expected seg=7f en=7", seg, digit_en);
          end else passed++;
        end
      end
    end
  endtask

  task automatic test_mode();
    load(16'h00AF, 1'b0);
    for (int i = 0; i < ND * RD + 2; i++) begin
      step();
      checks++;
      if ({seg, digit_en, seg_nh, digit_en_nh} !== {exp_seg, exp_en, exp_seg_nh, exp_en}) begin
        $display("FAIL mode: seg=%h seg_nh=%h en=%h, expected seg=%h seg_nh=%h en=%h",
                 seg, seg_nh, digit_en, exp_seg, exp_seg_nh, exp_en);
      end else passed++;
      if (!exp_busy && m_idx == 1) begin
        checks++;
        if ({seg, seg_nh} !== {~7'h77, ~7'h40}) begin
          $display("FAIL mode_digit1: seg=%h seg_nh=%h, expected seg=%h seg_nh=%h", seg, seg_nh, ~7'h77, ~7'h40);
        end else passed++;
      end
    end
  endtask

  task automatic test_midslot_load();
    int budget = 0;
    while (!((m_n % RD) == 2 && ((m_n / RD) % ND) == 2) && budget < 64) begin
      step();
      budget++;
    end
    checks++;
    if (budget >= 64) $display("FAIL midslot_wait: budget %0d expired, required reach of digit 2 slot", budget);
    else passed++;
    load(16'h8888, 1'b0);
    step();
    checks++;
    if ({seg, digit_en, busy} !== {7'h00, 4'hB, 1'b0}) begin
      $display("FAIL midslot_load: seg=%h en=%h busy=%b, expected seg=00 en=b busy=0", seg, digit_en, busy);
    end else passed++;
  endtask

  task automatic test_random();
    logic [15:0] v;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        v = 16'($urandom);
        for (int d = 0; d < 4; d++) if ($urandom_range(0, 2) == 0) v[4*d +: 4] = 4'h0;
        value = v; lz_en = 1'($urandom); ready = 1'b1;
      end else begin
        ready = 1'b0;
        value = 16'($urandom);
      end
      step();
      checks++;
      if ({seg, digit_en, busy, seg_nh, digit_en_nh, busy_nh} !== {exp_seg, exp_en, exp_busy, exp_seg_nh, exp_en, exp_busy}) begin
        $display("FAIL random: seg=%h en=%h busy=%b seg_nh=%h, expected seg=%h en=%h busy=%b seg_nh=%h",
                 seg, digit_en, busy, seg_nh, exp_seg, exp_en, exp_busy, exp_seg_nh);
      end else passed++;
    end
    ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int budget = 0;
    while (!((m_n % RD) == 2 && ((m_n / RD) % ND) == 3) && budget < 64) begin
      step();
      budget++;
    end
    reset = 1'b1; ready = 1'b1; value = 16'h9999; lz_en = 1'b1;
    step();
    checks++;
    if ({seg, digit_en, busy} !== {7'h7F, 4'hF, 1'b1}) begin
      $display("FAIL reset_mid_scan: seg=%h en=%h busy=%b, expected seg=7f en=f busy=1", seg, digit_en, busy);
    end else passed++;
    reset = 1'b0; ready = 1'b0;
    for (int i = 0; i < 2 * RD; i++) begin
      step();
      checks++;
      if ({seg, digit_en, busy} !== {exp_seg, exp_en, exp_busy}) begin
        $display("FAIL reset_shadow_cleared: seg=%h en=%h busy=%b, expected seg=%h en=%h busy=%b",
                 seg, digit_en, busy, exp_seg, exp_en, exp_busy);
      end else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_leading_zero();
    test_mode();
    test_midslot_load();
    test_random();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/notas_display_mux.md
# notas_display_mux

Time-multiplexed driver for a bank of common-anode seven-segment displays, successor to the single-digit combinational segment decoder. It latches a packed vector of 4-bit digit codes on a `ready` strobe, scans the digits one at a time at a programmable refresh rate with dead time between digits, and applies optional leading-zero suppression. It sits between the result/score logic and the board display pins.

## Interface
- `NUM_DIGITS`, 4: digits in the bank (1..8).
- `REFRESH_DIV`, 50000: clock cycles per digit slot (≥2).
- `ACTIVE_LOW`, 1: 1 means `seg` and `digit_en` are driven active-low (lit/enabled = 0).
- `HEX_MODE`, 1: 1 means codes 10..15 display A,b,C,d,E,F; 0 means codes 10..15 display a single dash (segment g only).
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `ready`  in  1: load strobe; samples `value` and `lz_en` into the shadow register.
- `value`  in  4*NUM_DIGITS: packed codes, digit i = `value[4i+3:4i]`, digit 0 rightmost/least significant.
- `lz_en`  in  1: leading-zero suppression enable.
- `seg`  out  7: segments, `seg[0]`..`seg[6]` = a..g (s0..s6).
- `digit_en`  out  NUM_DIGITS: one-hot (per polarity) digit select.
- `busy`  out  1: high during dead-time cycles; a `ready` pulse during busy is still accepted.

## Operation
- Reset: shadow code register = 0, shadow lz = 0, divider = 0, scan index = 0; `seg` = all segments off (7'h7F when ACTIVE_LOW), `digit_en` = all disabled, `busy` = 1.
- Load: `ready`=1 at an edge copies `value`/`lz_en` into shadow. No handshake back; every pulse is taken; back-to-back pulses keep the last.
- Divider counts 0..REFRESH_DIV-1, then wraps to 0 and scan index advances i → i+1, NUM_DIGITS-1 → 0.
- Slot: divider = 0 is dead time (all digits disabled, segments off, busy=1); divider 1..REFRESH_DIV-1 enables digit[index] with its decoded pattern, busy=0.
- Decode (active-high pattern, inverted when ACTIVE_LOW): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F; HEX_MODE: A=77,b=7C,C=39,d=5E,E=79,F=71; else 10..15=40.
- Leading-zero suppression (shadow lz=1): digit i is blanked (segments off, digit still enabled) when code i and all more-significant codes are 0. Digit 0 is never blanked.
- Reset mid-scan: next edge returns to reset values regardless of divider/index; reset dominates a simultaneous `ready`.

## Timing
- All outputs registered; decode is from shadow state of the previous cycle.
- `ready` at edge t → shadow at t → visible on `seg` at edge t+1 if current slot is active.
- First active digit after reset release: digit 0 enabled at edge 2 after reset deasserts (edge 1 is dead time).
- Full scan period = NUM_DIGITS × REFRESH_DIV cycles; each digit active REFRESH_DIV-1 cycles.
- Index and divider wrap simultaneously; no cycle with two digits enabled.

## Structure
- Package `notas_pkg`: 7-bit segment pattern constants (0..F, dash, blank), code width localparam (4).
- Sub-module `seg7_decode`: pure combinational code + hex_mode → active-high pattern; polarity inversion and blanking in the top.
- Top holds shadow register, divider, scan index, leading-zero mask, output registers.

## Test plan
- Reset: hold reset 3 cycles with NUM_DIGITS=4, REFRESH_DIV=4 → `seg`=7F, `digit_en`=4'hF, busy=1 throughout and one cycle after release.
- Scan: load value=16'h1234 → sequence per 4-cycle slot: dead, then digit_en=4'hE seg=~7'h66 (4), next slot 4'hD ~7'h4F (3), 4'hB ~7'h5B (2), 4'h7 ~7'h06 (1), wrap.
- Leading zeros: value=16'h0070, lz_en=1 → digits 3,2 segments 7F while enabled; digit 1 ~7'h07; digit 0 ~7'h3F; value=0 → only digit 0 shows 0.
- Mode: value=16'h00AF, HEX_MODE=1 → digit 0 ~7'h71, digit 1 ~7'h77; HEX_MODE=0 → both ~7'h40.
- Mid-slot load: ready with 16'h8888 mid-slot of digit 2 → `seg` changes to 7'h00 next cycle, no extra dead time.
- Reset while scanning at index 3 with simultaneous ready → next cycle reset values, shadow=0.
